instr_fetch_unit: RTL and testbench

//  Requester side of the instruction RAM read port: drives the fetch address, captures the

---
 rtl/instr_fetch_unit_if.sv | 22 ++
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 tb/tb_instr_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Core-facing instruction handshake and redirect bundle for instr_fetch_unit.
// master = fetch unit (drives instructions), slave = core (accepts, redirects).
interface instr_fetch_unit_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_opcode;
  logic [15:0] instr_operand;
  logic        instr_two_word;
  logic [15:0] instr_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  modport master (
    output instr_valid, instr_opcode, instr_operand, instr_two_word, instr_pc,
    input  instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  instr_valid, instr_opcode, instr_operand, instr_two_word, instr_pc,
    output instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch requester: reads 1- or 2-word instructions from a 1-cycle-latency RAM
// and offers them to the core. Optional handshake counter built when IFU_PERF_CNT_EN is defined.
//
// state   | meaning
// REQ_OP  | iram_addr = pc, RAM samples opcode address
// CAP_OP  | capture opcode, decide instruction length
// REQ_OPR | RAM samples pc+1 (operand address)
// CAP_OPR | capture operand word
// VALID   | instruction offered, wait for handshake
// HALT    | ENDOP consumed, frozen until rst
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'd0,
  parameter logic [15:0] OP_LDAC  = 16'd7,
  parameter logic [15:0] OP_STAC  = 16'd11,
  parameter logic [15:0] OP_JUMP  = 16'd31,
  parameter logic [15:0] OP_JUMPZ = 16'd33,
  parameter logic [15:0] OP_ENDOP = 16'd37
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [15:0]           iram_addr,
  input  logic [15:0]           iram_data,
  instr_fetch_unit_if.master    core,
  output logic                  halted,
  output logic [31:0]           fetch_count
);

  typedef enum logic [2:0] {REQ_OP, CAP_OP, REQ_OPR, CAP_OPR, VALID, HALT} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic [15:0] pc_plus1;
  logic        handshake;
  logic        op_has_operand;

  assign handshake      = core.instr_valid & core.instr_ready;
  assign pc_plus1       = pc + 16'd1;
  assign pc_next        = pc + (core.instr_two_word ? 16'd2 : 16'd1);
  assign op_has_operand = (iram_data == OP_LDAC) || (iram_data == OP_STAC) ||
                          (iram_data == OP_JUMP) || (iram_data == OP_JUMPZ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= REQ_OP;
      pc                  <= RESET_PC;
      iram_addr           <= RESET_PC;
      core.instr_valid    <= 1'b0;
      core.instr_opcode   <= 16'd0;
      core.instr_operand  <= 16'd0;
      core.instr_two_word <= 1'b0;
      core.instr_pc       <= 16'd0;
      halted              <= 1'b0;
    end else if (state != HALT) begin
      // An ENDOP handshake beats a simultaneous redirect.
      if (handshake && core.instr_opcode == OP_ENDOP) begin
        pc               <= pc_next;
        iram_addr        <= pc_next;
        core.instr_valid <= 1'b0;
        halted           <= 1'b1;
        state            <= HALT;
      end else if (core.redirect_valid) begin
        pc               <= core.redirect_pc;
        iram_addr        <= core.redirect_pc;
        core.instr_valid <= 1'b0;
        state            <= REQ_OP;
      end else begin
        case (state)
          REQ_OP: state <= CAP_OP;
          CAP_OP: begin
            core.instr_opcode <= iram_data;
            core.instr_pc     <= pc;
            if (op_has_operand) begin
              iram_addr           <= pc_plus1;
              core.instr_two_word <= 1'b1;
              state               <= REQ_OPR;
            end else begin
              core.instr_operand  <= 16'd0;
              core.instr_two_word <= 1'b0;
              core.instr_valid    <= 1'b1;
              state               <= VALID;
            end
          end
          REQ_OPR: state <= CAP_OPR;
          CAP_OPR: begin
            core.instr_operand <= iram_data;
            core.instr_valid   <= 1'b1;
            state              <= VALID;
          end
          VALID: begin
            if (handshake) begin
              pc               <= pc_next;
              iram_addr        <= pc_next;
              core.instr_valid <= 1'b0;
              state            <= REQ_OP;
            end
          end
          default: state <= REQ_OP;
        endcase
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)            fetch_count <= 32'd0;
    else if (handshake) fetch_count <= fetch_count + 32'd1;
  end
`else
  assign fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table-driven instruction stream plus redirect,
// halt, address-wrap and mid-fetch reset sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst1;
  logic [15:0] iram_addr, iram_data, iram_addr1, iram_data1;
  logic        halted, halted1;
  logic [31:0] fetch_count, fetch_count1;
  logic [15:0] mem  [0:65535];
  logic [15:0] mem1 [0:65535];

  instr_fetch_unit_if bus ();
  instr_fetch_unit_if bus1 ();

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .iram_addr(iram_addr), .iram_data(iram_data),
    .core(bus), .halted(halted), .fetch_count(fetch_count)
  );

  instr_fetch_unit #(.RESET_PC(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst1), .iram_addr(iram_addr1), .iram_data(iram_data1),
    .core(bus1), .halted(halted1), .fetch_count(fetch_count1)
  );

  always @(posedge clk) iram_data  <= mem[iram_addr];
  always @(posedge clk) iram_data1 <= mem1[iram_addr1];

  int hs_count;
  always @(posedge clk) begin
    if (rst) hs_count <= 0;
    else if (bus.instr_valid && bus.instr_ready) hs_count <= hs_count + 1;
  end

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef IFU_PERF_CNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset();
    chk("rst_iram_addr", {16'd0, iram_addr}, 32'd0);
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_opcode", {16'd0, bus.instr_opcode}, 32'd0);
    chk("rst_operand", {16'd0, bus.instr_operand}, 32'd0);
    chk("rst_pc", {16'd0, bus.instr_pc}, 32'd0);
    chk("rst_two_word", {31'd0, bus.instr_two_word}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset();
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.instr_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.instr_valid) chk("valid_timeout", {31'd0, bus.instr_valid}, 32'd1);
  endtask

  task automatic handshake();
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
  endtask

  task automatic chk_instr(input string tag, input logic [15:0] op, input logic [15:0] opr,
                           input logic tw, input logic [15:0] pc);
    chk({tag, "_opcode"}, {16'd0, bus.instr_opcode}, {16'd0, op});
    chk({tag, "_operand"}, {16'd0, bus.instr_operand}, {16'd0, opr});
    chk({tag, "_two_word"}, {31'd0, bus.instr_two_word}, {31'd0, tw});
    chk({tag, "_pc"}, {16'd0, bus.instr_pc}, {16'd0, pc});
  endtask

  task automatic load_main();
    mem[0] = 16'd7;  mem[1] = 16'd25;  mem[2] = 16'd15; mem[3] = 16'd11;
    mem[4] = 16'd100; mem[5] = 16'd3; mem[6] = 16'd33; mem[7] = 16'd500;
    mem[8] = 16'd1;
  endtask

  typedef struct {
    logic [15:0] op;
    logic [15:0] opr;
    logic        tw;
    logic [15:0] pc;
    int          lat;
    int          stall;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int cyc;
    logic [15:0] nxt;
    logic [15:0] h_op, h_opr, h_pc, h_addr;
    logic        h_tw;

    vecs[0] = '{op: 16'd7,  opr: 16'd25,  tw: 1'b1, pc: 16'd0, lat: 4, stall: 5};
    vecs[1] = '{op: 16'd15, opr: 16'd0,   tw: 1'b0, pc: 16'd2, lat: 2, stall: 0};
    vecs[2] = '{op: 16'd11, opr: 16'd100, tw: 1'b1, pc: 16'd3, lat: 4, stall: 0};
    vecs[3] = '{op: 16'd3,  opr: 16'd0,   tw: 1'b0, pc: 16'd5, lat: 2, stall: 1};
    vecs[4] = '{op: 16'd33, opr: 16'd500, tw: 1'b1, pc: 16'd6, lat: 4, stall: 2};
    vecs[5] = '{op: 16'd1,  opr: 16'd0,   tw: 1'b0, pc: 16'd8, lat: 2, stall: 0};

    for (int i = 0; i < 65536; i++) begin
      mem[i]  = 16'd0;
      mem1[i] = 16'd0;
    end
    mem1[16'hFFFF] = 16'd11;
    mem1[0]        = 16'd65000;
    mem1[1]        = 16'd15;
    rst1 = 1'b1;
    bus1.instr_ready = 1'b0;
    bus1.redirect_valid = 1'b0;
    bus1.redirect_pc = 16'd0;
    bus.redirect_pc = 16'd0;
    load_main();

    // Table-driven instruction stream, including stalled VALID.
    do_reset();
    rst = 1'b0;
    foreach (vecs[i]) begin
      wait_valid(cyc);
      chk($sformatf("v%0d_latency", i), cyc, vecs[i].lat);
      chk_instr($sformatf("v%0d", i), vecs[i].op, vecs[i].opr, vecs[i].tw, vecs[i].pc);
      h_addr = iram_addr;
      for (int s = 0; s < vecs[i].stall; s++) begin
        @(negedge clk);
        chk($sformatf("v%0d_stall_valid", i), {31'd0, bus.instr_valid}, 32'd1);
        chk($sformatf("v%0d_stall_addr", i), {16'd0, iram_addr}, {16'd0, h_addr});
        chk_instr($sformatf("v%0d_stall", i), vecs[i].op, vecs[i].opr, vecs[i].tw, vecs[i].pc);
      end
      handshake();
      nxt = vecs[i].pc + (vecs[i].tw ? 16'd2 : 16'd1);
      chk($sformatf("v%0d_valid_drop", i), {31'd0, bus.instr_valid}, 32'd0);
      chk($sformatf("v%0d_next_addr", i), {16'd0, iram_addr}, {16'd0, nxt});
      chk($sformatf("v%0d_fetch_count", i), fetch_count, exp_cnt(hs_count));
    end

    // Redirect in the middle of a 2-word fetch discards the partial instruction.
    do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'd5;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("midredir_addr", {16'd0, iram_addr}, 32'd5);
    chk("midredir_valid", {31'd0, bus.instr_valid}, 32'd0);
    wait_valid(cyc);
    chk("midredir_latency", cyc, 2);
    chk_instr("midredir", 16'd3, 16'd0, 1'b0, 16'd5);
    handshake();

    // Taken jump: redirect together with the handshake, then ENDOP halts.
    mem[0] = 16'd31; mem[1] = 16'd24; mem[2] = 16'd99; mem[24] = 16'd37;
    do_reset();
    rst = 1'b0;
    wait_valid(cyc);
    chk_instr("jump", 16'd31, 16'd24, 1'b1, 16'd0);
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'd24;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("jump_redir_addr", {16'd0, iram_addr}, 32'd24);
    chk("jump_valid_drop", {31'd0, bus.instr_valid}, 32'd0);
    chk("jump_fetch_count", fetch_count, exp_cnt(1));
    wait_valid(cyc);
    chk("endop_latency", cyc, 2);
    chk_instr("endop", 16'd37, 16'd0, 1'b0, 16'd24);
    handshake();
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("halt_fetch_count", fetch_count, exp_cnt(2));
    h_addr = iram_addr;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'd0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("halt_addr_frozen", {16'd0, iram_addr}, 32'd25);
      chk("halt_stays", {31'd0, halted}, 32'd1);
      chk("halt_no_valid", {31'd0, bus.instr_valid}, 32'd0);
    end
    bus.redirect_valid = 1'b0;

    // Reset while in CAP_OPR aborts the fetch and restarts from RESET_PC.
    mem[0] = 16'd7; mem[1] = 16'd25; mem[2] = 16'd15;
    do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    wait_valid(cyc);
    chk("rerun_latency", cyc, 4);
    chk_instr("rerun0", 16'd7, 16'd25, 1'b1, 16'd0);
    handshake();
    wait_valid(cyc);
    chk_instr("rerun1", 16'd15, 16'd0, 1'b0, 16'd2);
    handshake();
    chk("rerun_fetch_count", fetch_count, exp_cnt(2));

    // Address wrap with RESET_PC = 0xFFFF on the second instance.
    @(negedge clk);
    chk("wrap_reset_addr", {16'd0, iram_addr1}, 32'h0000FFFF);
    rst1 = 1'b0;
    cyc = 0;
    while (!bus1.instr_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("wrap_valid", {31'd0, bus1.instr_valid}, 32'd1);
    chk("wrap_opcode", {16'd0, bus1.instr_opcode}, 32'd11);
    chk("wrap_operand", {16'd0, bus1.instr_operand}, 32'd65000);
    chk("wrap_pc", {16'd0, bus1.instr_pc}, 32'h0000FFFF);
    chk("wrap_two_word", {31'd0, bus1.instr_two_word}, 32'd1);
    bus1.instr_ready = 1'b1;
    @(negedge clk);
    bus1.instr_ready = 1'b0;
    chk("wrap_next_addr", {16'd0, iram_addr1}, 32'd1);
    cyc = 0;
    while (!bus1.instr_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("wrap_next_latency", cyc, 2);
    chk("wrap_next_pc", {16'd0, bus1.instr_pc}, 32'd1);
    chk("wrap_next_opcode", {16'd0, bus1.instr_opcode}, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
